// File: rtl/alu_add.sv
// rtl/alu_add.sv - registered two-operand adder with carry/overflow/zero/negative flags (optional saturation via ADD_SATURATE_EN)
module alu_add #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             cin,
`ifdef ADD_SATURATE_EN
    input  logic             sat_signed,
`endif
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             out_valid
);

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    logic [WIDTH:0]   sum_full;
    logic [WIDTH-1:0] sum_raw;
    logic             carry_raw;
    logic             ovf_raw;
    logic [WIDTH-1:0] sum_final;

    // Full-width sum; the extra top bit is the unsigned carry-out.
    always_comb begin
        sum_full  = {1'b0, opA} + {1'b0, opB} + {{WIDTH{1'b0}}, cin};
        sum_raw   = sum_full[WIDTH-1:0];
        carry_raw = sum_full[WIDTH];
        // Signed overflow: operands agree in sign but the wrapped sum does not.
        ovf_raw   = (opA[WIDTH-1] == opB[WIDTH-1]) && (sum_raw[WIDTH-1] != opA[WIDTH-1]);
    end

`ifdef ADD_SATURATE_EN
    // Clamp the sum; carry/overflow flags still report the raw condition.
    always_comb begin
        sum_final = sum_raw;
        if (sat_signed) begin
            if (ovf_raw) begin
                sum_final = opA[WIDTH-1] ? MIN_NEG : MAX_POS;
            end
        end else if (carry_raw) begin
            sum_final = ALL_ONE;
        end
    end
`else
    // Without saturation the result simply wraps modulo 2^WIDTH.
    always_comb begin
        sum_final = sum_raw;
    end
`endif

    // Output register: capture only on in_valid so idle operands never disturb held values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= sum_final;
                carry    <= carry_raw;
                overflow <= ovf_raw;
                zero     <= (sum_final == '0);
                negative <= sum_final[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_alu_add.sv
// tb/tb_alu_add.sv - scoreboard testbench for alu_add
module tb_alu_add;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         cin;
    logic         sat_signed;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         negative;
    logic         out_valid;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
        logic         n;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_check = 0;
    bit   started = 1'b0;

    alu_add #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .opA       (opA),
        .opB       (opB),
        .cin       (cin),
`ifdef ADD_SATURATE_EN
        .sat_signed(sat_signed),
`endif
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_check++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sat);
        exp_t e;
        logic [W:0] s;
        s   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e.r = s[W-1:0];
        e.c = s[W];
        e.o = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
`ifdef ADD_SATURATE_EN
        if (sat && e.o)       e.r = a[W-1] ? 8'h80 : 8'h7F;
        else if (!sat && e.c) e.r = 8'hFF;
`endif
        e.z   = (e.r == 0);
        e.n   = e.r[W-1];
        e.cyc = 0;
        return e;
    endfunction

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic sat, input logic v);
        exp_t e;
        @(negedge clk);
        in_valid   = v;
        opA        = a;
        opB        = b;
        cin        = ci;
        sat_signed = sat;
        if (v) begin
            e     = model(a, b, ci, sat);
            e.cyc = cyc;
            q.push_back(e);
        end
    endtask

    // Output monitor: out_valid must follow exactly one cycle after each pushed stimulus.
    always @(negedge clk) begin
        if (started && rst_n) begin
            exp_t e;
            bit   exp_v;
            exp_v = (q.size() > 0) && (q[0].cyc == cyc - 1);
            check("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
            if (exp_v) begin
                e = q.pop_front();
                check("result",   {56'd0, result},   {56'd0, e.r});
                check("carry",    {63'd0, carry},    {63'd0, e.c});
                check("overflow", {63'd0, overflow}, {63'd0, e.o});
                check("zero",     {63'd0, zero},     {63'd0, e.z});
                check("negative", {63'd0, negative}, {63'd0, e.n});
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_result"},    {56'd0, result},    64'd0);
        check({tag, "_carry"},     {63'd0, carry},     64'd0);
        check({tag, "_overflow"},  {63'd0, overflow},  64'd0);
        check({tag, "_zero"},      {63'd0, zero},      64'd0);
        check({tag, "_negative"},  {63'd0, negative},  64'd0);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; opA = '0; opB = '0; cin = 1'b0; sat_signed = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(posedge clk); #2 rst_n = 1'b1;
        started = 1'b1;

        // Directed cases
        drive(8'd15,  8'd3,   1'b0, 1'b0, 1'b1);
        drive(8'hFF,  8'h01,  1'b0, 1'b0, 1'b1);
        drive(8'h7F,  8'h01,  1'b0, 1'b1, 1'b1);
`ifdef ADD_SATURATE_EN
        drive(8'h80,  8'hFF,  1'b0, 1'b1, 1'b1);
        drive(8'hF0,  8'h20,  1'b0, 1'b0, 1'b1);
`endif
        drive(8'h10,  8'h0F,  1'b1, 1'b0, 1'b1);

        // Idle with unknown operands: result must hold 0x20
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0; opA = 'x; opB = 'x; cin = 1'bx;
            @(posedge clk); #1;
            check("hold_result",    {56'd0, result},    64'h20);
            check("hold_out_valid", {63'd0, out_valid}, 64'd0);
        end

        // Random mix of valid and idle cycles
        for (int i = 0; i < 60; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        // Reset mid-stream
        drive(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        drive(8'h7F, 8'h7F, 1'b1, 1'b0, 1'b1);
        drive(8'hC0, 8'h40, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0; in_valid = 1'b0;
        q.delete();
        #1 check_all_zero("midrst");
        @(posedge clk); #2 rst_n = 1'b1;

        drive(8'h21, 8'h12, 1'b0, 1'b0, 1'b1);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        check("drained", 64'(q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

endmodule
